// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 asynchronous serial receiver.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   data_out   last correctly received byte (LSB = first data bit)
//   data_valid one-cycle pulse, data_out has just been updated
//   frame_err  one-cycle pulse, stop bit sampled low
//   busy       high whenever a frame is in progress (state != IDLE)
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CW       = $clog2(CLKS_PER_BIT);

  // The counter reads N-1 in cycle N of a state, so sample points compare
  // against one less than the nominal offset.
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } state_t;

  state_t          state;
  logic            rx_q1;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  // Two-flop synchroniser; resets to idle-high so no false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  // Receive FSM with baud counter, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      cnt        <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state   <= START;
            bit_idx <= '0;
            busy    <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK_WAIT;
            end
          end
        end

        BREAK_WAIT: begin
          // Hold off until the line returns high so a break cannot retrigger.
          if (rx_s) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed self-checking bench for uart_receiver.
module tb_uart_receiver;

  localparam int unsigned C = 16;
  // Observed cycle of the data_valid/frame_err pulse relative to the
  // cycle count at which the start bit is driven: 2 sync flops + 153.
  localparam int unsigned PULSE_OFS = 155;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int checks;
  int errors;

  int cyc;
  int busy_cnt;
  int ferr_cnt;
  int overlap_cnt;
  int ferr_cyc;
  int valid_cyc[$];
  logic [7:0] valid_dat[$];

  uart_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (data_valid) begin
      valid_cyc.push_back(cyc);
      valid_dat.push_back(data_out);
    end
    if (frame_err) begin
      ferr_cnt <= ferr_cnt + 1;
      ferr_cyc <= cyc;
    end
    if (data_valid && frame_err) overlap_cnt <= overlap_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic clear_mon();
    valid_cyc.delete();
    valid_dat.delete();
    ferr_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  // Serialise one frame starting at a falling edge; t0 = cycle count at start.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    t0 = cyc;
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) hold(d[i], C);
    hold(stop, C);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", data_valid); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int t0;
    clear_mon();
    send_frame(8'hA5, 1'b1, t0);
    hold(1'b1, 20);
    checks++;
    if (valid_cyc.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", valid_cyc.size()); end
    else begin
      checks++;
      if (valid_cyc[0] != t0 + PULSE_OFS) begin errors++; $display("FAIL single_time got %0d want %0d", valid_cyc[0] - t0, PULSE_OFS); end
      checks++;
      if (valid_dat[0] !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", valid_dat[0]); end
    end
    checks++;
    if (ferr_cnt != 0) begin errors++; $display("FAIL single_ferr got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_glitch();
    clear_mon();
    hold(1'b0, 4);
    hold(1'b1, 30);
    checks++;
    if (busy_cnt != 8) begin errors++; $display("FAIL glitch_busy got %0d want 8", busy_cnt); end
    checks++;
    if (valid_cyc.size() != 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", valid_cyc.size()); end
    checks++;
    if (ferr_cnt != 0) begin errors++; $display("FAIL glitch_ferr got %0d want 0", ferr_cnt); end
    checks++;
    if (data_out !== 8'hA5) begin errors++; $display("FAIL glitch_data got %h want a5", data_out); end
  endtask

  task automatic test_frame_err();
    int t0;
    clear_mon();
    send_frame(8'h3C, 1'b0, t0);
    hold(1'b0, 40);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_hold got %b want 1", busy); end
    checks++;
    if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_count got %0d want 1", ferr_cnt); end
    checks++;
    if (ferr_cyc != t0 + PULSE_OFS) begin errors++; $display("FAIL ferr_time got %0d want %0d", ferr_cyc - t0, PULSE_OFS); end
    hold(1'b1, 6);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got %b want 0", busy); end
    checks++;
    if (valid_cyc.size() != 0) begin errors++; $display("FAIL ferr_valid got %0d want 0", valid_cyc.size()); end
    checks++;
    if (data_out !== 8'hA5) begin errors++; $display("FAIL ferr_data got %h want a5", data_out); end
    hold(1'b1, 20);
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    clear_mon();
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    hold(1'b1, 20);
    checks++;
    if (valid_cyc.size() != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", valid_cyc.size()); end
    else begin
      checks++;
      if (valid_dat[0] !== 8'h00) begin errors++; $display("FAIL b2b_data0 got %h want 00", valid_dat[0]); end
      checks++;
      if (valid_dat[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1 got %h want ff", valid_dat[1]); end
      checks++;
      if (valid_cyc[1] - valid_cyc[0] != 160) begin errors++; $display("FAIL b2b_spacing got %0d want 160", valid_cyc[1] - valid_cyc[0]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int t0;
    d = 8'h5A;
    clear_mon();
    hold(1'b0, C);
    for (int i = 0; i < 3; i++) hold(d[i], C);
    hold(d[3], C / 2);
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", data_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 10);
    checks++;
    if (valid_cyc.size() != 0 || ferr_cnt != 0) begin
      errors++; $display("FAIL midrst_pulse got %0d/%0d want 0/0", valid_cyc.size(), ferr_cnt);
    end
    send_frame(8'h81, 1'b1, t0);
    hold(1'b1, 20);
    checks++;
    if (valid_cyc.size() != 1 || valid_dat[0] !== 8'h81) begin
      errors++; $display("FAIL midrst_next got n=%0d data=%h want n=1 data=81", valid_cyc.size(), data_out);
    end
  endtask

  // Behavioural transmitter driving rx back-to-back, one stop bit each.
  task automatic test_loopback();
    logic [7:0] exp_b[4];
    int t0;
    exp_b[0] = 8'h00; exp_b[1] = 8'h55; exp_b[2] = 8'hAA; exp_b[3] = 8'hFF;
    clear_mon();
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1, t0);
    hold(1'b1, 20);
    checks++;
    if (valid_cyc.size() != 4) begin errors++; $display("FAIL loop_count got %0d want 4", valid_cyc.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (valid_dat[i] !== exp_b[i]) begin errors++; $display("FAIL loop_byte%0d got %h want %h", i, valid_dat[i], exp_b[i]); end
      end
    end
    checks++;
    if (ferr_cnt != 0) begin errors++; $display("FAIL loop_ferr got %0d want 0", ferr_cnt); end
  endtask

  initial begin
    checks = 0; errors = 0;
    cyc = 0; busy_cnt = 0; ferr_cnt = 0; overlap_cnt = 0; ferr_cyc = 0;
    rx = 1'b1;
    rst_n = 1'b1;
    #1;
    @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    checks++;
    if (overlap_cnt != 0) begin errors++; $display("FAIL pulse_overlap got %0d want 0", overlap_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
